gpio_ctrl: RTL and testbench
============================

Name: gpio_ctrl

Overview:
- Parametrised successor to the fixed 16-bit GPIO register file: NUM_PINS-wide GPIO with input synchronisers, per-pin edge-detect interrupts, mask, and a write-1-to-clear pending register.
- Sits on the router's register port (reg_addr/reg_wben/reg_rwn/reg_write/reg_read).
- Drives a per-pin and an aggregate interrupt into the core's ext_interrupts.

Parameters:
- NUM_PINS, 16, number of GPIO pins (1..32); register bits at or above NUM_PINS read 0 and ignore writes.
- SYNC_STAGES, 2, pin-input synchroniser depth (2..4).
- ADDR_W, 3, register word-address width.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- addr  in  ADDR_W  register word index.
- wben  in  4  byte-lane write enables; wben[i] covers wdata[8i+7:8i].
- r_wn  in  1  1 = read, 0 = write; access every cycle.
- wdata  in  32  write data.
- rdata  out  32  registered read data.
- ro_gpio_pinstate  in  NUM_PINS  asynchronous pad inputs.
- rf_gpio_datareg  out  NUM_PINS  output data register.
- rf_gpio_tristate  out  NUM_PINS  1 = pin hi-Z (input), 0 = driven.
- irq_pins  out  NUM_PINS  per-pin interrupt: IPEND & IMASK.
- irq  out  1  OR-reduction of irq_pins.

Behaviour:
- Register map by addr:
  - 0 DATA (RW)
  - 1 TRIS (RW)
  - 2 PIN (RO, synchronised pin state)
  - 3 IMASK (RW)
  - 4 IRISE (RW, rising-edge enable)
  - 5 IFALL (RW, falling-edge enable)
  - 6 IPEND (RW1C)
  - 7 ISTAT (RO, IPEND & IMASK)
- Reset values:
  - DATA, IMASK, IRISE, IFALL, IPEND, synchroniser flops, edge-history flops and rdata = 0.
  - TRIS = all ones (every pin an input).
  - So irq = 0 and irq_pins = 0 during and after reset.
- Write (r_wn = 0): on the rising clk edge, each enabled byte lane updates RW registers.
  - Writes to PIN and ISTAT are ignored.
  - IPEND: a 1 written in an enabled lane clears that bit; a 0 leaves it unchanged.
- Read (r_wn = 1): rdata is loaded at the rising edge with the addressed register, zero-extended to 32 bits.
  - Valid one cycle after addr is presented.
  - During write cycles rdata holds its previous value.
  - Reads have no side effects; reading IPEND does not clear it.
- Synchroniser: SYNC_STAGES flop chain per pin; PIN = last stage. A pad change sampled at edge N is visible in PIN after edge N+SYNC_STAGES-1.
- Edge detect: hist <= PIN every cycle.
  - rise = PIN & ~hist & IRISE; fall = ~PIN & hist & IFALL.
  - Pending is set on the edge after the change appears in PIN, i.e. SYNC_STAGES+1 edges after first sampling.
- IPEND update: IPEND_next = (IPEND & ~clr) | rise | fall. Set wins over a simultaneous W1C clear of the same bit.
- IMASK gates only irq_pins/irq/ISTAT, never pending capture. A masked edge still sets IPEND.
- Changing IRISE/IFALL never creates pending by itself; only a PIN transition does. A pin held high when IRISE is enabled produces no interrupt.
- Pulse shorter than one clk may be missed (not guaranteed). Pulses of SYNC_STAGES+1 cycles or more are guaranteed captured.
- Output timing: irq_pins/irq are combinational from IPEND and IMASK flops, so there is no extra latency and they are glitch-free relative to clk.
- Reset asserted mid-operation: all state returns to the reset values immediately (asynchronous). The first edge after release resumes normal operation with no spurious pending, because the enables are 0.
- Out-of-range bits: bits ≥ NUM_PINS are zero in all registers and outputs.

Decomposition:
- Shared package gpio_pkg:
  - register index constants (GPIO_DATA=0 … GPIO_ISTAT=7);
  - TRIS reset-value constant;
  - max-pin constant (32).
- One sub-module, gpio_sync_edge: NUM_PINS-wide synchroniser chain plus history flop; outputs PIN, rise_raw and fall_raw.
- Top module holds the register file, W1C logic, read mux and interrupt reduction.

Test Plan:
- Reset check: release reset; read addrs 0..7 → DATA=0, TRIS=0xFFFF, PIN=pad value, others 0; irq=0.
- Byte-lane write: write DATA=0x1234_ABCD with wben=4'b0001 → rf_gpio_datareg=0x00CD; reading DATA returns 0x0000_00CD one cycle later.
- Rising-edge interrupt: IRISE=0x0001, IMASK=0x0001; drive pad[0] 0→1.
  - IPEND[0]=1 and irq=1 exactly SYNC_STAGES+1 edges later.
  - Write IPEND=0x0001 → irq=0 the next cycle.
- Masked and falling edge: IFALL=0x8000, IMASK=0; drive pad[15] 1→0.
  - IPEND=0x8000, irq=0, ISTAT=0.
  - Set IMASK=0x8000 → irq=1 and ISTAT=0x8000 next cycle.
- Set/clear collision: arrange a pad[3] rising edge to set IPEND[3] on the same edge as a W1C write of 0x0008 → IPEND[3] stays 1.
- Asynchronous reset mid-run: with IPEND=0x00FF and irq=1, assert reset between clk edges → irq, irq_pins and rdata go to 0 immediately, before the next clk edge.

Source files
------------

// File: rtl/gpio_pkg.sv
// Shared constants and helpers for the parametrised GPIO register block.
package gpio_pkg;

  localparam int GPIO_DATA  = 0;
  localparam int GPIO_TRIS  = 1;
  localparam int GPIO_PIN   = 2;
  localparam int GPIO_IMASK = 3;
  localparam int GPIO_IRISE = 4;
  localparam int GPIO_IFALL = 5;
  localparam int GPIO_IPEND = 6;
  localparam int GPIO_ISTAT = 7;

  localparam int          GPIO_MAX_PINS = 32;
  localparam logic [31:0] TRIS_RESET    = 32'hFFFF_FFFF;

  // Expands byte-lane write enables into a 32-bit bit mask.
  function automatic logic [31:0] lane_mask(input logic [3:0] wben);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) begin
      m[8*i +: 8] = {8{wben[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// Pad-input synchroniser chain with a history flop for edge detection.
module gpio_sync_edge #(
  parameter int NUM_PINS    = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_PINS-1:0] pad_i,
  output logic [NUM_PINS-1:0] pin_o,
  output logic [NUM_PINS-1:0] rise_raw_o,
  output logic [NUM_PINS-1:0] fall_raw_o
);

  logic [SYNC_STAGES-1:0][NUM_PINS-1:0] sync_q, sync_d;
  logic [NUM_PINS-1:0]                  hist_q, hist_d;

  always_comb begin
    sync_d[0] = pad_i;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
    hist_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= '0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign pin_o      = sync_q[SYNC_STAGES-1];
  assign rise_raw_o = pin_o & ~hist_q;
  assign fall_raw_o = ~pin_o & hist_q;

endmodule

// File: rtl/gpio_ctrl.sv
// GPIO register file: data/tristate outputs, synchronised pin readback,
// edge-triggered pending interrupts with mask and write-1-to-clear.
module gpio_ctrl
  import gpio_pkg::*;
#(
  parameter int NUM_PINS    = 16,
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [3:0]          wben,
  input  logic                r_wn,
  input  logic [31:0]         wdata,
  output logic [31:0]         rdata,
  input  logic [NUM_PINS-1:0] ro_gpio_pinstate,
  output logic [NUM_PINS-1:0] rf_gpio_datareg,
  output logic [NUM_PINS-1:0] rf_gpio_tristate,
  output logic [NUM_PINS-1:0] irq_pins,
  output logic                irq
);

  logic [NUM_PINS-1:0] data_q, data_d, tris_q, tris_d;
  logic [NUM_PINS-1:0] imask_q, imask_d, irise_q, irise_d;
  logic [NUM_PINS-1:0] ifall_q, ifall_d, ipend_q, ipend_d;
  logic [31:0]         rdata_q, rdata_d;

  logic [NUM_PINS-1:0] pin, rise_raw, fall_raw;
  logic [NUM_PINS-1:0] wm, wv, clr;
  logic [31:0]         wr_mask, wr_bits;
  logic                unused_wr;

  gpio_sync_edge #(
    .NUM_PINS    (NUM_PINS),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk        (clk),
    .rst_n      (reset),
    .pad_i      (ro_gpio_pinstate),
    .pin_o      (pin),
    .rise_raw_o (rise_raw),
    .fall_raw_o (fall_raw)
  );

  assign wr_mask   = lane_mask(wben);
  assign wr_bits   = wdata & wr_mask;
  assign wm        = wr_mask[NUM_PINS-1:0];
  assign wv        = wr_bits[NUM_PINS-1:0];
  assign unused_wr = ^{wr_mask, wr_bits};

  function automatic logic [31:0] zext(input logic [NUM_PINS-1:0] v);
    logic [31:0] r;
    r = '0;
    r[NUM_PINS-1:0] = v;
    return r;
  endfunction

  always_comb begin
    data_d  = data_q;
    tris_d  = tris_q;
    imask_d = imask_q;
    irise_d = irise_q;
    ifall_d = ifall_q;
    clr     = '0;
    if (!r_wn) begin
      case (addr)
        ADDR_W'(GPIO_DATA):  data_d  = (data_q  & ~wm) | wv;
        ADDR_W'(GPIO_TRIS):  tris_d  = (tris_q  & ~wm) | wv;
        ADDR_W'(GPIO_IMASK): imask_d = (imask_q & ~wm) | wv;
        ADDR_W'(GPIO_IRISE): irise_d = (irise_q & ~wm) | wv;
        ADDR_W'(GPIO_IFALL): ifall_d = (ifall_q & ~wm) | wv;
        ADDR_W'(GPIO_IPEND): clr     = wv;
        default: ;
      endcase
    end
    // New edges are OR-ed in after the clear so a coincident set wins.
    ipend_d = (ipend_q & ~clr) | (rise_raw & irise_q) | (fall_raw & ifall_q);

    rdata_d = rdata_q;
    if (r_wn) begin
      case (addr)
        ADDR_W'(GPIO_DATA):  rdata_d = zext(data_q);
        ADDR_W'(GPIO_TRIS):  rdata_d = zext(tris_q);
        ADDR_W'(GPIO_PIN):   rdata_d = zext(pin);
        ADDR_W'(GPIO_IMASK): rdata_d = zext(imask_q);
        ADDR_W'(GPIO_IRISE): rdata_d = zext(irise_q);
        ADDR_W'(GPIO_IFALL): rdata_d = zext(ifall_q);
        ADDR_W'(GPIO_IPEND): rdata_d = zext(ipend_q);
        ADDR_W'(GPIO_ISTAT): rdata_d = zext(ipend_q & imask_q);
        default:             rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q  <= '0;
      tris_q  <= TRIS_RESET[NUM_PINS-1:0];
      imask_q <= '0;
      irise_q <= '0;
      ifall_q <= '0;
      ipend_q <= '0;
      rdata_q <= '0;
    end else begin
      data_q  <= data_d;
      tris_q  <= tris_d;
      imask_q <= imask_d;
      irise_q <= irise_d;
      ifall_q <= ifall_d;
      ipend_q <= ipend_d;
      rdata_q <= rdata_d;
    end
  end

  assign rdata            = rdata_q;
  assign rf_gpio_datareg  = data_q;
  assign rf_gpio_tristate = tris_q;
  assign irq_pins         = ipend_q & imask_q;
  assign irq              = |irq_pins;

endmodule

// File: tb/tb_gpio_ctrl.sv
// Directed-vector bench for gpio_ctrl with hand-computed expected values.
module tb_gpio_ctrl;

  localparam int NP = 16;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [2:0]    addr;
  logic [3:0]    wben;
  logic          r_wn;
  logic [31:0]   wdata;
  logic [31:0]   rdata;
  logic [NP-1:0] pad;
  logic [NP-1:0] datareg, tristate, irq_pins;
  logic          irq;

  int n_vec  = 0;
  int n_miss = 0;

  gpio_ctrl #(.NUM_PINS(NP), .SYNC_STAGES(SS), .ADDR_W(3)) dut (
    .clk              (clk),
    .reset            (rst_n),
    .addr             (addr),
    .wben             (wben),
    .r_wn             (r_wn),
    .wdata            (wdata),
    .rdata            (rdata),
    .ro_gpio_pinstate (pad),
    .rf_gpio_datareg  (datareg),
    .rf_gpio_tristate (tristate),
    .irq_pins         (irq_pins),
    .irq              (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drive a write for one posedge; returns at the following negedge.
  task automatic wr(input logic [2:0] a, input logic [3:0] be, input logic [31:0] d);
    addr = a; wben = be; wdata = d; r_wn = 1'b0;
    @(negedge clk);
    r_wn = 1'b1; addr = 3'd0; wben = 4'h0; wdata = '0;
  endtask

  task automatic rd(input string tag, input logic [2:0] a, input logic [31:0] exp);
    addr = a; r_wn = 1'b1;
    @(negedge clk);
    chk(tag, rdata, exp);
    addr = 3'd0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; addr = '0; wben = '0; r_wn = 1'b1; wdata = '0;
    pad = 16'h8000;
    idle(2);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_irq_pins", {16'd0, irq_pins}, 32'd0);
    chk("rst_tris", {16'd0, tristate}, 32'h0000_FFFF);
    chk("rst_rdata", rdata, 32'd0);
    rst_n = 1'b1;
    idle(4);

    rd("rd_data",  3'd0, 32'h0);
    rd("rd_tris",  3'd1, 32'h0000_FFFF);
    rd("rd_pin",   3'd2, 32'h0000_8000);
    rd("rd_imask", 3'd3, 32'h0);
    rd("rd_irise", 3'd4, 32'h0);
    rd("rd_ifall", 3'd5, 32'h0);
    rd("rd_ipend", 3'd6, 32'h0);
    rd("rd_istat", 3'd7, 32'h0);
    chk("post_rst_irq", {31'd0, irq}, 32'd0);

    // Byte-lane writes and out-of-range bits
    wr(3'd0, 4'b0001, 32'h1234_ABCD);
    chk("data_lane0", {16'd0, datareg}, 32'h0000_00CD);
    rd("rd_data_lane0", 3'd0, 32'h0000_00CD);
    wr(3'd0, 4'b0010, 32'hFFFF_5600);
    rd("rd_data_lane1", 3'd0, 32'h0000_56CD);
    wr(3'd0, 4'b1111, 32'hFFFF_FFFF);
    rd("rd_data_oor", 3'd0, 32'h0000_FFFF);
    wr(3'd1, 4'b0011, 32'h0000_0F0F);
    chk("tris_wr", {16'd0, tristate}, 32'h0000_0F0F);
    wr(3'd2, 4'b1111, 32'h0);
    rd("pin_ro", 3'd2, 32'h0000_8000);

    // Rising edge with exact latency; held-high pin15 must not trigger
    wr(3'd4, 4'b0011, 32'h0000_8001);
    wr(3'd3, 4'b0011, 32'h0000_0001);
    idle(4);
    rd("held_high_nopend", 3'd6, 32'h0);
    pad[0] = 1'b1;
    for (int i = 0; i < SS; i++) begin
      @(negedge clk);
      chk($sformatf("rise_early%0d", i), {31'd0, irq}, 32'd0);
    end
    @(negedge clk);
    chk("rise_irq", {31'd0, irq}, 32'd1);
    rd("rise_ipend", 3'd6, 32'h0000_0001);
    rd("ipend_noclr_on_rd", 3'd6, 32'h0000_0001);
    wr(3'd6, 4'b0001, 32'h0000_0001);
    chk("w1c_irq", {31'd0, irq}, 32'd0);
    chk("w1c_irq_pins", {16'd0, irq_pins}, 32'd0);

    // Masked falling edge on pin15
    wr(3'd4, 4'b0011, 32'h0000_0001);
    wr(3'd5, 4'b0011, 32'h0000_8000);
    wr(3'd3, 4'b0011, 32'h0000_0000);
    pad[15] = 1'b0;
    idle(4);
    rd("fall_ipend", 3'd6, 32'h0000_8000);
    chk("fall_masked_irq", {31'd0, irq}, 32'd0);
    rd("fall_istat_masked", 3'd7, 32'h0);
    wr(3'd3, 4'b0011, 32'h0000_8000);
    chk("unmask_irq", {31'd0, irq}, 32'd1);
    rd("unmask_istat", 3'd7, 32'h0000_8000);
    wr(3'd6, 4'b0010, 32'h0000_8000);
    rd("fall_clr", 3'd6, 32'h0);

    // Set wins over simultaneous W1C on pin3
    wr(3'd4, 4'b0011, 32'h0000_0009);
    pad[3] = 1'b1;
    idle(SS);
    wr(3'd6, 4'b0001, 32'h0000_0008);
    rd("collide_set_wins", 3'd6, 32'h0000_0008);
    wr(3'd6, 4'b0001, 32'h0000_0008);
    rd("collide_then_clr", 3'd6, 32'h0);

    // Async reset mid-run with IPEND=0x00FF and irq asserted
    pad[7:0] = 8'h00;
    idle(4);
    wr(3'd6, 4'b0011, 32'h0000_FFFF);
    wr(3'd4, 4'b0011, 32'h0000_00FF);
    pad[7:0] = 8'hFF;
    idle(4);
    wr(3'd3, 4'b0011, 32'h0000_00FF);
    rd("pre_rst_ipend", 3'd6, 32'h0000_00FF);
    chk("pre_rst_irq", {31'd0, irq}, 32'd1);
    chk("pre_rst_irq_pins", {16'd0, irq_pins}, 32'h0000_00FF);
    #2 rst_n = 1'b0;
    #1;
    chk("async_irq", {31'd0, irq}, 32'd0);
    chk("async_irq_pins", {16'd0, irq_pins}, 32'd0);
    chk("async_rdata", rdata, 32'd0);
    chk("async_data", {16'd0, datareg}, 32'd0);
    chk("async_tris", {16'd0, tristate}, 32'h0000_FFFF);
    @(negedge clk);
    rst_n = 1'b1;
    idle(5);
    rd("post_rst_ipend", 3'd6, 32'h0);
    rd("post_rst_pin", 3'd2, 32'h0000_00FF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
